poly_tone_synth: RTL and testbench

- Parametrised multi-voice successor to the single-voice square-wave speaker driver.
- Generates NUM_VOICES independent square-wave tones from note/octave codes. Each voice has a linear attack/release envelope.
- Voice levels are mixed and delivered to the amplifier as a single-bit PWM stream on AIN.
- Sits between the keypad/note decoder and the amplifier module pins (AIN, GAIN, NC, ACTIVE).

---
 rtl/poly_tone_synth.sv | 159 +++++++++++++++
 tb/tb_poly_tone_synth.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_synth.sv
// Multi-voice square-wave tone synthesiser with linear attack/release envelopes,
// a registered voice mixer and a single-bit PWM output stage for the amplifier.
module poly_tone_synth #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned ENV_DIV     = 100000,
  parameter int unsigned ENV_STEP    = 8,
  parameter int unsigned TONE_SHIFT  = 0,
  parameter bit          GAIN_LOW_DB = 1'b1
) (
  input  logic                              clk_100M,
  input  logic                              rst_n,
  input  logic [NUM_VOICES-1:0]             voice_gate,
  input  logic [3*NUM_VOICES-1:0]           voice_note,
  input  logic [3*NUM_VOICES-1:0]           voice_octave,
  output logic [8+$clog2(NUM_VOICES+1)-1:0] mix_level,
  output logic                              AIN,
  output logic                              GAIN,
  output logic                              NC,
  output logic                              ACTIVE
);

  localparam int unsigned MixW    = 8 + $clog2(NUM_VOICES + 1);
  localparam int unsigned PwmMax  = NUM_VOICES * 255 - 1;
  localparam int unsigned PwmW    = $clog2(NUM_VOICES * 255);
  localparam int unsigned EnvCntW = $clog2(ENV_DIV);

  function automatic logic [31:0] base_period(input logic [2:0] note);
    case (note)
      3'd1:    return 32'd1528902;
      3'd2:    return 32'd1362097;
      3'd3:    return 32'd1213491;
      3'd4:    return 32'd1145383;
      3'd5:    return 32'd1020420;
      3'd6:    return 32'd909091;
      3'd7:    return 32'd809908;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] half_period(input logic [2:0] note, input logic [2:0] oct);
    logic [31:0] hp;
    hp = base_period(note) >> (32'(oct) + TONE_SHIFT);
    return (hp < 32'd2) ? 32'd2 : hp;
  endfunction

  function automatic logic [7:0] env_up(input logic [7:0] env);
    logic [8:0] sum;
    sum = {1'b0, env} + 9'(ENV_STEP);
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  function automatic logic [7:0] env_down(input logic [7:0] env);
    return (env >= 8'(ENV_STEP)) ? env - 8'(ENV_STEP) : 8'd0;
  endfunction

  logic [NUM_VOICES-1:0] gate_dly_q, gate_dly_d;
  logic [NUM_VOICES-1:0] sq_q, sq_d;
  logic [2:0]            note_q [NUM_VOICES];
  logic [2:0]            note_d [NUM_VOICES];
  logic [2:0]            oct_q  [NUM_VOICES];
  logic [2:0]            oct_d  [NUM_VOICES];
  logic [31:0]           cnt_q  [NUM_VOICES];
  logic [31:0]           cnt_d  [NUM_VOICES];
  logic [7:0]            env_q  [NUM_VOICES];
  logic [7:0]            env_d  [NUM_VOICES];
  logic [EnvCntW-1:0]    env_div_q, env_div_d;
  logic                  tick;
  logic [MixW-1:0]       mix_q, mix_d;
  logic [PwmW-1:0]       pwm_q, pwm_d;
  logic                  ain_q, ain_d;
  logic                  active_q, active_d;

  // Per-voice note latch, tone counter and envelope.
  always_comb begin
    tick      = (env_div_q == EnvCntW'(ENV_DIV - 1));
    env_div_d = tick ? '0 : env_div_q + 1'b1;
    gate_dly_d = voice_gate;
    sq_d       = sq_q;
    note_d     = note_q;
    oct_d      = oct_q;
    cnt_d      = cnt_q;
    env_d      = env_q;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (voice_gate[i] && !gate_dly_q[i]) begin
        note_d[i] = voice_note[3*i +: 3];
        oct_d[i]  = voice_octave[3*i +: 3];
        cnt_d[i]  = 32'd1;
        sq_d[i]   = 1'b0;
      end else if (voice_gate[i] || env_q[i] != 8'd0) begin
        if (note_q[i] == 3'd0) begin
          sq_d[i] = 1'b0;
        end else if (cnt_q[i] >= half_period(note_q[i], oct_q[i])) begin
          sq_d[i]  = ~sq_q[i];
          cnt_d[i] = 32'd1;
        end else begin
          cnt_d[i] = cnt_q[i] + 32'd1;
        end
      end else begin
        sq_d[i]  = 1'b0;
        cnt_d[i] = 32'd1;
      end
      // The envelope runs independently of the latch, so a rise and a tick can coincide.
      if (tick) begin
        env_d[i] = voice_gate[i] ? env_up(env_q[i]) : env_down(env_q[i]);
      end
    end
  end

  // Mixer, PWM and amplifier enable all work from registered voice state.
  always_comb begin
    mix_d    = '0;
    active_d = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (sq_q[i]) begin
        mix_d = mix_d + MixW'(env_q[i]);
      end
      if (voice_gate[i] || env_q[i] != 8'd0) begin
        active_d = 1'b1;
      end
    end
    pwm_d = (pwm_q == PwmW'(PwmMax)) ? '0 : pwm_q + 1'b1;
    ain_d = (MixW'(pwm_q) < mix_q);
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      gate_dly_q <= '0;
      sq_q       <= '0;
      note_q     <= '{default: '0};
      oct_q      <= '{default: '0};
      cnt_q      <= '{default: '0};
      env_q      <= '{default: '0};
      env_div_q  <= '0;
      mix_q      <= '0;
      pwm_q      <= '0;
      ain_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      gate_dly_q <= gate_dly_d;
      sq_q       <= sq_d;
      note_q     <= note_d;
      oct_q      <= oct_d;
      cnt_q      <= cnt_d;
      env_q      <= env_d;
      env_div_q  <= env_div_d;
      mix_q      <= mix_d;
      pwm_q      <= pwm_d;
      ain_q      <= ain_d;
      active_q   <= active_d;
    end
  end

  assign mix_level = mix_q;
  assign AIN       = ain_q;
  assign ACTIVE    = active_q;
  assign GAIN      = GAIN_LOW_DB;
  assign NC        = 1'b0;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Self-checking bench for poly_tone_synth: directed tables and sequences plus random
// stimulus, all compared every cycle against a time-based behavioural model.
`timescale 1ns/1ps
module tb_poly_tone_synth;
  localparam int NV    = 2;
  localparam int EDIV  = 4;
  localparam int ESTEP = 64;
  localparam int TSH   = 10;
  localparam int PWM_N = NV * 255;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] gate  = '0;
  logic [5:0] note  = '0;
  logic [5:0] oct   = '0;
  logic [9:0] mix;
  logic       ain, gain, nc, active;

  int checks = 0;
  int errors = 0;

  poly_tone_synth #(
    .NUM_VOICES (NV),
    .ENV_DIV    (EDIV),
    .ENV_STEP   (ESTEP),
    .TONE_SHIFT (TSH),
    .GAIN_LOW_DB(1'b1)
  ) dut (
    .clk_100M    (clk),
    .rst_n       (rst_n),
    .voice_gate  (gate),
    .voice_note  (note),
    .voice_octave(oct),
    .mix_level   (mix),
    .AIN         (ain),
    .GAIN        (gain),
    .NC          (nc),
    .ACTIVE      (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: square phase derives from elapsed cycles since the latch, not a counter.
  int m_cyc;
  int m_latch [NV];
  int m_note  [NV];
  int m_oct   [NV];
  int m_env   [NV];
  bit m_run   [NV];
  bit m_gprev [NV];
  bit m_sq    [NV];
  int m_mix;
  bit m_ain, m_active;

  function automatic int hp_of(input int n, input int o);
    int base;
    int hp;
    case (n)
      1: base = 1528902;
      2: base = 1362097;
      3: base = 1213491;
      4: base = 1145383;
      5: base = 1020420;
      6: base = 909091;
      7: base = 809908;
      default: base = 0;
    endcase
    hp = base >> (o + TSH);
    return (hp < 2) ? 2 : hp;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_mix = 0; m_ain = 0; m_active = 0;
    for (int v = 0; v < NV; v++) begin
      m_latch[v] = 0; m_note[v] = 0; m_oct[v] = 0; m_env[v] = 0;
      m_run[v] = 0; m_gprev[v] = 0; m_sq[v] = 0;
    end
  endtask

  task automatic model_edge();
    int nmix;
    bit nact, nain, tick, g, sounding;
    nmix = 0;
    nact = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_sq[v]) nmix += m_env[v];
      if (gate[v] || m_env[v] != 0) nact = 1;
    end
    nain = (m_cyc % PWM_N) < m_mix;
    tick = (m_cyc % EDIV) == EDIV - 1;
    for (int v = 0; v < NV; v++) begin
      g = gate[v];
      sounding = g || m_env[v] != 0;
      if (g && !m_gprev[v]) begin
        m_latch[v] = m_cyc;
        m_note[v]  = int'(note[3*v +: 3]);
        m_oct[v]   = int'(oct[3*v +: 3]);
        m_run[v]   = 1;
      end else if (!sounding) begin
        m_run[v] = 0;
      end
      if (tick) m_env[v] = g ? ((m_env[v] + ESTEP > 255) ? 255 : m_env[v] + ESTEP)
                             : ((m_env[v] - ESTEP < 0) ? 0 : m_env[v] - ESTEP);
      m_gprev[v] = g;
      m_sq[v] = m_run[v] && m_note[v] != 0 &&
                (((m_cyc - m_latch[v]) / hp_of(m_note[v], m_oct[v])) % 2 == 1);
    end
    m_mix = nmix; m_ain = nain; m_active = nact;
    m_cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("mix_level", int'(mix), m_mix);
    check("AIN", int'(ain), int'(m_ain));
    check("ACTIVE", int'(active), int'(m_active));
  endtask

  task automatic wait_mix(input int val, input int bound, input string name);
    int n = 0;
    while (int'(mix) != val && n < bound) begin cycle(); n++; end
    check(name, int'(mix), val);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (active && n < 200) begin cycle(); n++; end
    check("idle", int'(active), 0);
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    check("rst mix_level", int'(mix), 0);
    check("rst AIN", int'(ain), 0);
    check("rst ACTIVE", int'(active), 0);
    check("rst GAIN", int'(gain), 1);
    check("rst NC", int'(nc), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int note;
    int oct;
    int chg;
    int period;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int rel_exp[4];
    int n, prev, cnt, seen_mix, seen_ain;
    tbl[0] = '{note: 1, oct: 0, chg: 1, period: 1493};
    tbl[1] = '{note: 1, oct: 3, chg: 1, period: 186};
    tbl[2] = '{note: 1, oct: 0, chg: 6, period: 1493};
    tbl[3] = '{note: 6, oct: 0, chg: 6, period: 887};
    tbl[4] = '{note: 7, oct: 7, chg: 7, period: 6};
    tbl[5] = '{note: 1, oct: 7, chg: 1, period: 11};
    rel_exp = '{191, 127, 63, 0};

    @(negedge clk);
    reset_pulse();

    // Half-period per note/octave; a note change while gated must be ignored.
    for (int i = 0; i < 6; i++) begin
      note = {3'd0, 3'(tbl[i].note)};
      oct  = {3'd0, 3'(tbl[i].oct)};
      gate = 2'b01;
      repeat (5) cycle();
      note[2:0] = 3'(tbl[i].chg);
      repeat (25) cycle();
      prev = int'(mix); n = 0;
      while (int'(mix) == prev && n < 5000) begin cycle(); n++; end
      prev = int'(mix); n = 0;
      while (int'(mix) == prev && n < 5000) begin cycle(); n++; end
      check($sformatf("period[%0d]", i), n, tbl[i].period);
      gate = 2'b00;
      wait_idle();
    end

    // Release staircase and ACTIVE drop.
    note = 6'o01; oct = '0; gate = 2'b01;
    wait_mix(255, 3000, "mix_up");
    gate = 2'b00;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) check("active_before_zero", int'(active), 1);
      prev = int'(mix); n = 0;
      while (int'(mix) == prev && n < 20) begin cycle(); n++; end
      check($sformatf("release[%0d]", j), int'(mix), rel_exp[j]);
      if (j == 1 || j == 2) check("release_spacing", n, EDIV);
    end
    check("active_after_zero", int'(active), 0);

    // PWM: full scale, then half scale.
    note = 6'o11; oct = '0; gate = 2'b11;
    wait_mix(510, 3000, "mix_full");
    cycle();
    cnt = 0;
    repeat (PWM_N) begin cycle(); cnt += int'(ain); end
    check("ain_full", cnt, 510);
    gate = 2'b00;
    wait_idle();
    note = 6'o10; gate = 2'b11;
    wait_mix(255, 3000, "mix_half");
    cycle();
    cnt = 0;
    repeat (PWM_N) begin cycle(); cnt += int'(ain); end
    check("ain_half", cnt, 255);
    gate = 2'b00;
    wait_idle();

    // Silent note: envelope runs but nothing reaches the mixer.
    note = '0; gate = 2'b01;
    seen_mix = 0; seen_ain = 0;
    repeat (40) begin cycle(); seen_mix |= int'(mix); seen_ain |= int'(ain); end
    check("silent_active", int'(active), 1);
    check("silent_mix", seen_mix, 0);
    check("silent_ain", seen_ain, 0);
    gate = 2'b00;
    wait_idle();

    // Reset while notes are sounding.
    note = 6'o77; oct = 6'o77; gate = 2'b11;
    repeat (50) cycle();
    reset_pulse();
    repeat (20) cycle();

    // Random gates, notes and octaves against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int v = 0; v < NV; v++) begin
        if ($urandom_range(0, 29) == 0) gate[v] = ~gate[v];
        if ($urandom_range(0, 9) == 0) note[3*v +: 3] = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) oct[3*v +: 3] = 3'($urandom_range(3, 7));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
